// File: rtl/matrix_mac_array.sv
// matrix_mac_array: memory-mapped signed matrix multiply, C = A x B.
// CORE_COUNT MAC lanes compute one row tile of C (CORE_COUNT columns) per pass.
// Build option MATRIX_SAT_EN: saturating accumulate with a sticky overflow flag in
// STATUS bit 3. Without it the accumulators wrap and STATUS bit 3 reads 0.
module matrix_mac_array #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CORE_COUNT = 4,
  parameter int unsigned ROW_MAX    = 8,
  parameter int unsigned COL_MAX    = 8
) (
  input  logic        CLOCK_25,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [12:0] address,
  input  logic        we,
  output logic [31:0] o_data_rdt,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned RW = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;
  localparam int unsigned CW = (COL_MAX > 1) ? $clog2(COL_MAX) : 1;
  localparam int unsigned PW = 2 * DATA_W;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StMac   = 3'd2;
  localparam logic [2:0] StStore = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegA      = 3'd1;
  localparam logic [2:0] RegB      = 3'd2;
  localparam logic [2:0] RegC      = 3'd3;
  localparam logic [2:0] RegStatus = 3'd4;

  // Bus decode
  logic [2:0] w_region;
  logic [4:0] w_row;
  logic [4:0] w_col;
  logic       w_wr_ok;
  logic       w_start;
  logic       w_bad_size;
  logic       w_a_in_range;
  logic       w_b_in_range;
  logic       w_c_in_range;
  logic       w_unused_data;

  // Storage
  logic signed [DATA_W-1:0] r_a [ROW_MAX][COL_MAX];
  logic signed [DATA_W-1:0] r_b [COL_MAX][ROW_MAX];
  logic signed [DATA_W-1:0] r_c [ROW_MAX][ROW_MAX];

  // Control and status
  logic [2:0]    r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [23:0]   r_ctrl;
  logic [RW-1:0] r_i;
  logic [RW-1:0] r_j0;
  logic [CW-1:0] r_k;
  logic [31:0]   r_rdata;
  logic          w_k_last;
  logic          w_more_cols;
  logic          w_more_rows;
  logic          w_ovf_flag;

  // Lane datapath
  logic signed [DATA_W-1:0] r_acc      [CORE_COUNT];
  logic signed [DATA_W-1:0] w_acc_nxt  [CORE_COUNT];
  logic signed [DATA_W-1:0] w_b_op     [CORE_COUNT];
  logic        [RW:0]       w_lane_col [CORE_COUNT];
`ifdef MATRIX_SAT_EN
  localparam logic signed [DATA_W-1:0] SatMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SatMin = {1'b1, {(DATA_W-1){1'b0}}};
  logic signed [PW-1:0] w_prod [CORE_COUNT];
  logic signed [PW:0]   w_sum  [CORE_COUNT];
  logic                 w_ovf_any;
  logic                 r_ovf;
`else
  // Wrapping only needs the low half of the full product.
  logic signed [DATA_W-1:0] w_prod [CORE_COUNT];
`endif

  assign w_region = address[12:10];
  assign w_row    = address[9:5];
  assign w_col    = address[4:0];

  // r_busy is low only in IDLE, so this also confines starts to IDLE.
  assign w_wr_ok = we && !r_busy;
  assign w_start = w_wr_ok && (w_region == RegCtrl) && data[24];

  assign w_bad_size = (data[7:0] == 8'd0) || (data[15:8] == 8'd0) || (data[23:16] == 8'd0) ||
                      (32'(data[7:0]) > ROW_MAX) || (32'(data[23:16]) > ROW_MAX) ||
                      (32'(data[15:8]) > COL_MAX);

  assign w_a_in_range = (32'(w_row) < ROW_MAX) && (32'(w_col) < COL_MAX);
  assign w_b_in_range = (32'(w_row) < COL_MAX) && (32'(w_col) < ROW_MAX);
  assign w_c_in_range = (32'(w_row) < ROW_MAX) && (32'(w_col) < ROW_MAX);

  assign w_unused_data = ^data[31:25];

  assign w_k_last    = (8'(r_k) == (r_ctrl[15:8] - 8'd1));
  assign w_more_cols = (9'(r_j0) + 9'(CORE_COUNT)) < {1'b0, r_ctrl[23:16]};
  assign w_more_rows = 8'(r_i) < (r_ctrl[7:0] - 8'd1);

  // Per-lane multiply-accumulate for the current k.
  always_comb begin
`ifdef MATRIX_SAT_EN
    w_ovf_any = 1'b0;
`endif
    for (int g = 0; g < CORE_COUNT; g++) begin
      w_lane_col[g] = {1'b0, r_j0} + (RW+1)'(g);
      // Lanes beyond the array edge multiply by zero; they are masked at STORE anyway.
      w_b_op[g] = (32'(w_lane_col[g]) < ROW_MAX) ? r_b[r_k][w_lane_col[g][RW-1:0]] : '0;
`ifdef MATRIX_SAT_EN
      w_prod[g] = PW'(r_a[r_i][r_k]) * PW'(w_b_op[g]);
      w_sum[g]  = (PW+1)'(r_acc[g]) + (PW+1)'(w_prod[g]);
      if (w_sum[g] > (PW+1)'(SatMax)) begin
        w_acc_nxt[g] = SatMax;
        w_ovf_any    = 1'b1;
      end else if (w_sum[g] < (PW+1)'(SatMin)) begin
        w_acc_nxt[g] = SatMin;
        w_ovf_any    = 1'b1;
      end else begin
        w_acc_nxt[g] = w_sum[g][DATA_W-1:0];
      end
`else
      w_prod[g]    = r_a[r_i][r_k] * w_b_op[g];
      w_acc_nxt[g] = r_acc[g] + w_prod[g];
`endif
    end
  end

  // Job sequencer: size check on start, then CLEAR/MAC/STORE per tile, then DONE.
  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_i     <= '0;
      r_j0    <= '0;
      r_k     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            if (w_bad_size) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_err   <= 1'b0;
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
              r_i     <= '0;
              r_j0    <= '0;
              r_state <= StClear;
            end
          end
        end
        StClear: begin
          r_k     <= '0;
          r_state <= StMac;
        end
        StMac: begin
          r_k <= r_k + CW'(1);
          if (w_k_last) begin
            r_state <= StStore;
          end
        end
        StStore: begin
          if (w_more_cols) begin
            r_j0    <= r_j0 + RW'(CORE_COUNT);
            r_state <= StClear;
          end else if (w_more_rows) begin
            r_i     <= r_i + RW'(1);
            r_j0    <= '0;
            r_state <= StClear;
          end else begin
            r_state <= StDone;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Lane accumulators: zeroed at the start of each tile, updated once per MAC cycle.
  always_ff @(posedge CLOCK_25) begin
    if (rst || (r_state == StClear)) begin
      for (int g = 0; g < CORE_COUNT; g++) begin
        r_acc[g] <= '0;
      end
    end else if (r_state == StMac) begin
      for (int g = 0; g < CORE_COUNT; g++) begin
        r_acc[g] <= w_acc_nxt[g];
      end
    end
  end

`ifdef MATRIX_SAT_EN
  // Sticky overflow: cleared by an accepted start, set by any saturating accumulate.
  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_ovf <= 1'b0;
    end else if ((r_state == StMac) && w_ovf_any) begin
      r_ovf <= 1'b1;
    end
  end
  assign w_ovf_flag = r_ovf;
`else
  assign w_ovf_flag = 1'b0;
`endif

  // Write back the finished tile; lanes at or past column N write nothing.
  always_ff @(posedge CLOCK_25) begin
    if (!rst && (r_state == StStore)) begin
      for (int g = 0; g < CORE_COUNT; g++) begin
        if (8'(w_lane_col[g]) < r_ctrl[23:16]) begin
          r_c[r_i][w_lane_col[g][RW-1:0]] <= r_acc[g];
        end
      end
    end
  end

  // Operand writes from the bus, locked out while a job runs.
  always_ff @(posedge CLOCK_25) begin
    if (!rst && w_wr_ok) begin
      if ((w_region == RegA) && w_a_in_range) begin
        r_a[w_row[RW-1:0]][w_col[CW-1:0]] <= data[DATA_W-1:0];
      end
      if ((w_region == RegB) && w_b_in_range) begin
        r_b[w_row[CW-1:0]][w_col[RW-1:0]] <= data[DATA_W-1:0];
      end
    end
  end

  // CTRL register; the start bit is not stored so it always reads back 0.
  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      r_ctrl <= '0;
    end else if (w_wr_ok && (w_region == RegCtrl)) begin
      r_ctrl <= data[23:0];
    end
  end

  // Registered read port, refreshed every cycle from the current address.
  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      case (w_region)
        RegCtrl:   r_rdata <= {8'd0, r_ctrl};
        RegC:      r_rdata <= w_c_in_range ? 32'(r_c[w_row[RW-1:0]][w_col[RW-1:0]]) : 32'd0;
        RegStatus: r_rdata <= {28'd0, w_ovf_flag, r_err, r_done, r_busy};
        default:   r_rdata <= 32'd0;
      endcase
    end
  end

  assign o_data_rdt = r_rdata;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
